// File: rtl/periph_bus_slave_pkg.sv
// periph_bus_slave_pkg: register offsets, TCON bit positions and UART state encoding
package periph_bus_slave_pkg;
    localparam logic [7:0] TH_ADDR     = 8'h00;
    localparam logic [7:0] TL_ADDR     = 8'h04;
    localparam logic [7:0] TCON_ADDR   = 8'h08;
    localparam logic [7:0] LED_ADDR    = 8'h0C;
    localparam logic [7:0] SWITCH_ADDR = 8'h10;
    localparam logic [7:0] DIGI_ADDR   = 8'h14;
    localparam logic [7:0] TXD_ADDR    = 8'h18;
    localparam logic [7:0] RXD_ADDR    = 8'h1C;
    localparam logic [7:0] UCON_ADDR   = 8'h20;
    localparam int TCON_EN  = 0;
    localparam int TCON_IE  = 1;
    localparam int TCON_IRQ = 2;
    typedef enum logic [1:0] {UART_IDLE, UART_START, UART_DATA, UART_STOP} uart_state_t;
endpackage

// File: rtl/periph_bus_slave_rx.sv
// uart_rx_core: synchronised UART receiver sampling mid-bit; pulses o_rx_strobe for one cycle per good byte
module uart_rx_core
    import periph_bus_slave_pkg::*;
#(
    parameter int BAUD_DIV = 5208
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_strobe
);
    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);

    logic [1:0]    r_sync;
    logic          r_prev;
    uart_state_t   r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [2:0]    r_bit, w_bit;
    logic [7:0]    r_shift, w_shift;
    logic          r_strobe, w_strobe;
    logic          w_rx;

    assign w_rx        = r_sync[1];
    assign o_rx_byte   = r_shift;
    assign o_rx_strobe = r_strobe;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync   <= 2'b11;
            r_prev   <= 1'b1;
            r_state  <= UART_IDLE;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_sync   <= {r_sync[0], i_rx};
            r_prev   <= w_rx;
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_bit    <= w_bit;
            r_shift  <= w_shift;
            r_strobe <= w_strobe;
        end
    end

    // START waits half a bit so every later sample lands mid-bit
    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt + 1'b1;
        w_bit    = r_bit;
        w_shift  = r_shift;
        w_strobe = 1'b0;
        case (r_state)
            UART_IDLE: begin
                w_cnt = '0;
                if (r_prev && !w_rx) w_state = UART_START;
            end
            UART_START: if (r_cnt == HALF) begin
                w_cnt   = '0;
                w_bit   = '0;
                w_state = w_rx ? UART_IDLE : UART_DATA;
            end
            UART_DATA: if (r_cnt == LAST) begin
                w_cnt   = '0;
                w_shift = {w_rx, r_shift[7:1]};
                w_bit   = r_bit + 1'b1;
                if (r_bit == 3'd7) w_state = UART_STOP;
            end
            UART_STOP: if (r_cnt == LAST) begin
                w_cnt    = '0;
                w_strobe = w_rx;
                w_state  = UART_IDLE;
            end
            default: w_state = UART_IDLE;
        endcase
    end
endmodule

// File: rtl/periph_bus_slave.sv
// periph_bus_slave: memory-mapped timer, LED, switch, digit and UART peripheral
module periph_bus_slave
    import periph_bus_slave_pkg::*;
#(
    parameter int BAUD_DIV = 5208
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  led,
    input  logic [7:0]  switch,
    output logic [11:0] digi,
    input  logic        UART_RX,
    output logic        UART_TX,
    output logic        irqout
);
    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [31:0]   r_th, r_tl;
    logic [2:0]    r_tcon;
    logic [7:0]    r_led, r_rxd;
    logic [11:0]   r_digi;
    logic          r_rx_valid, r_tx_done, r_tx_out;
    uart_state_t   r_tx_state, w_tx_state;
    logic [CW-1:0] r_tx_cnt, w_tx_cnt;
    logic [2:0]    r_tx_bit, w_tx_bit;
    logic [7:0]    r_tx_shift, w_tx_shift;
    logic          w_tx_fin, w_tx_tick, w_tx_busy, w_tx_out;
    logic [7:0]    w_off, w_rx_byte;
    logic          w_rx_strobe, w_wr_txd, w_rd_ucon, w_rd_rxd;
    logic          w_unused;

    assign w_unused  = &{1'b0, addr[31:8]};
    assign w_off     = addr[7:0];
    assign w_wr_txd  = wr && w_off == TXD_ADDR;
    assign w_rd_ucon = rd && w_off == UCON_ADDR;
    assign w_rd_rxd  = rd && w_off == RXD_ADDR;
    assign w_tx_tick = r_tx_cnt == LAST;
    assign w_tx_busy = r_tx_state != UART_IDLE;
    assign led       = r_led;
    assign digi      = r_digi;
    assign UART_TX   = r_tx_out;
    assign irqout    = r_tcon[TCON_IE] & r_tcon[TCON_IRQ];

    uart_rx_core #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .i_clk      (clk),
        .i_rst      (reset),
        .i_rx       (UART_RX),
        .o_rx_byte  (w_rx_byte),
        .o_rx_strobe(w_rx_strobe)
    );

    // CPU writes are applied after the timer update so they win over a reload
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_th       <= '0;
            r_tl       <= '0;
            r_tcon     <= '0;
            r_led      <= '0;
            r_digi     <= '0;
            r_rxd      <= '0;
            r_rx_valid <= 1'b0;
            r_tx_done  <= 1'b0;
        end else begin
            if (r_tcon[TCON_EN]) begin
                r_tl <= (r_tl == '1) ? r_th : r_tl + 1'b1;
                if (r_tl == '1 && r_tcon[TCON_IE]) r_tcon[TCON_IRQ] <= 1'b1;
            end
            if (wr && w_off == TH_ADDR) r_th <= wdata;
            if (wr && w_off == TL_ADDR) r_tl <= wdata;
            if (wr && w_off == TCON_ADDR) r_tcon <= wdata[2:0];
            if (wr && w_off == LED_ADDR) r_led <= wdata[7:0];
            if (wr && w_off == DIGI_ADDR) r_digi <= wdata[11:0];
            if (w_rx_strobe) r_rxd <= w_rx_byte;
            r_rx_valid <= w_rx_strobe | (r_rx_valid & ~w_rd_rxd);
            r_tx_done  <= w_tx_fin | (r_tx_done & ~w_rd_ucon);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_state <= UART_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_out   <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state;
            r_tx_cnt   <= w_tx_cnt;
            r_tx_bit   <= w_tx_bit;
            r_tx_shift <= w_tx_shift;
            r_tx_out   <= w_tx_out;
        end
    end

    always_comb begin
        w_tx_state = r_tx_state;
        w_tx_cnt   = r_tx_cnt + 1'b1;
        w_tx_bit   = r_tx_bit;
        w_tx_shift = r_tx_shift;
        w_tx_fin   = 1'b0;
        case (r_tx_state)
            UART_IDLE: begin
                w_tx_cnt = '0;
                if (w_wr_txd) begin
                    w_tx_shift = wdata[7:0];
                    w_tx_state = UART_START;
                end
            end
            UART_START: if (w_tx_tick) begin
                w_tx_cnt   = '0;
                w_tx_bit   = '0;
                w_tx_state = UART_DATA;
            end
            UART_DATA: if (w_tx_tick) begin
                w_tx_cnt = '0;
                w_tx_bit = r_tx_bit + 1'b1;
                if (r_tx_bit == 3'd7) w_tx_state = UART_STOP;
            end
            UART_STOP: if (w_tx_tick) begin
                w_tx_cnt   = '0;
                w_tx_fin   = 1'b1;
                w_tx_state = UART_IDLE;
            end
            default: w_tx_state = UART_IDLE;
        endcase
        w_tx_out = (w_tx_state == UART_START) ? 1'b0 :
                   (w_tx_state == UART_DATA)  ? w_tx_shift[w_tx_bit] : 1'b1;
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            case (w_off)
                TH_ADDR:     rdata = r_th;
                TL_ADDR:     rdata = r_tl;
                TCON_ADDR:   rdata = {29'd0, r_tcon};
                LED_ADDR:    rdata = {24'd0, r_led};
                SWITCH_ADDR: rdata = {24'd0, switch};
                DIGI_ADDR:   rdata = {20'd0, r_digi};
                RXD_ADDR:    rdata = {24'd0, r_rxd};
                UCON_ADDR:   rdata = {27'd0, w_tx_busy, r_rx_valid, r_tx_done, 2'b00};
                default:     rdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_periph_bus_slave.sv
// tb_periph_bus_slave: randomized scenario tests against a behavioural model of the register map, timer and UART
module tb_periph_bus_slave;
    import periph_bus_slave_pkg::*;
    localparam int BD = 16;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0, reset = 1'b1, rd = 1'b0, wr = 1'b0, UART_RX = 1'b1;
    logic [31:0] addr = '0, wdata = '0;
    logic [7:0]  switch = '0;
    logic [31:0] rdata;
    logic [7:0]  led;
    logic [11:0] digi;
    logic        UART_TX, irqout;
    int          errors = 0, checks = 0;
    logic [7:0]  last_rx = 8'h00;

    periph_bus_slave #(.BAUD_DIV(BD)) dut (
        .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata), .led(led), .switch(switch), .digi(digi),
        .UART_RX(UART_RX), .UART_TX(UART_TX), .irqout(irqout)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [7:0] off, input logic [31:0] d);
        wr = 1'b1; addr = BASE | {24'd0, off}; wdata = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] off, output logic [31:0] d);
        rd = 1'b1; addr = BASE | {24'd0, off};
        #1 d = rdata;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            UART_RX = f[i];
            repeat (BD) @(negedge clk);
        end
        UART_RX = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] offs [9];
        logic [31:0] d;
        offs = '{TH_ADDR, TL_ADDR, TCON_ADDR, LED_ADDR, SWITCH_ADDR, DIGI_ADDR, TXD_ADDR, RXD_ADDR, UCON_ADDR};
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checks++; if (UART_TX !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", UART_TX); end
        checks++; if ({led, digi, irqout} !== 21'd0) begin errors++; $display("FAIL reset_ports: got led=%h digi=%h irq=%b expected 0", led, digi, irqout); end
        foreach (offs[i]) begin
            bus_read(offs[i], d);
            checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_read %h: got %h expected 0", offs[i], d); end
        end
    endtask

    task automatic test_regs(input logic [7:0] lv, input logic [31:0] dv, input logic [7:0] sv);
        logic [31:0] d;
        bus_write(LED_ADDR, {$urandom_range(0, 255), lv} & 32'h0000_FFFF | {16'hFFFF, 16'h0} & $urandom);
        bus_write(DIGI_ADDR, dv);
        switch = sv;
        bus_write(SWITCH_ADDR, $urandom);
        bus_write(8'h24, $urandom);
        bus_read(LED_ADDR, d);
        checks++; if (d !== {24'd0, lv}) begin errors++; $display("FAIL led_read: got %h expected %h", d, {24'd0, lv}); end
        checks++; if (led !== lv) begin errors++; $display("FAIL led_port: got %h expected %h", led, lv); end
        bus_read(DIGI_ADDR, d);
        checks++; if (d !== {20'd0, dv[11:0]}) begin errors++; $display("FAIL digi_read: got %h expected %h", d, {20'd0, dv[11:0]}); end
        checks++; if (digi !== dv[11:0]) begin errors++; $display("FAIL digi_port: got %h expected %h", digi, dv[11:0]); end
        bus_read(SWITCH_ADDR, d);
        checks++; if (d !== {24'd0, sv}) begin errors++; $display("FAIL switch_read: got %h expected %h", d, {24'd0, sv}); end
        bus_read(8'h24, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL unmapped_read: got %h expected 0", d); end
        addr = BASE | {24'd0, LED_ADDR};
        #1;
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL rd_low: got %h expected 0", rdata); end
        @(negedge clk);
    endtask

    task automatic test_timer(input logic [31:0] th, input logic [31:0] tl0, input logic ie, input int n);
        logic [31:0] tl, d;
        logic st;
        bus_write(TH_ADDR, th);
        bus_write(TL_ADDR, tl0);
        bus_write(TCON_ADDR, {30'd0, ie, 1'b1});
        tl = tl0; st = 1'b0;
        for (int k = 0; k < n; k++) begin
            checks++; if (irqout !== (ie & st)) begin errors++; $display("FAIL timer_irq k=%0d: got %b expected %b", k, irqout, ie & st); end
            bus_read(TL_ADDR, d);
            checks++; if (d !== tl) begin errors++; $display("FAIL timer_tl k=%0d: got %h expected %h", k, d, tl); end
            if (tl == 32'hFFFF_FFFF) begin tl = th; st = st | ie; end else tl = tl + 1;
        end
        bus_read(TCON_ADDR, d);
        checks++; if (d !== {29'd0, st, ie, 1'b1}) begin errors++; $display("FAIL timer_tcon: got %h expected %h", d, {29'd0, st, ie, 1'b1}); end
        if (tl == 32'hFFFF_FFFF) tl = th; else tl = tl + 1;
        bus_write(TCON_ADDR, {30'd0, ie, 1'b1});
        if (tl == 32'hFFFF_FFFF) tl = th; else tl = tl + 1;
        checks++; if (irqout !== 1'b0) begin errors++; $display("FAIL timer_irq_clear: got %b expected 0", irqout); end
        bus_read(TL_ADDR, d);
        checks++; if (d !== tl) begin errors++; $display("FAIL timer_tl_after_clear: got %h expected %h", d, tl); end
        bus_write(TCON_ADDR, 32'd0);
    endtask

    task automatic test_tx(input logic [7:0] b, input logic second, input logic [7:0] b2);
        logic [9:0] fb;
        logic [31:0] d;
        int bad;
        fb = {1'b1, b, 1'b0};
        bus_write(TXD_ADDR, {24'd0, b});
        for (int k = 0; k < 10 * BD; k++) begin
            checks++; if (UART_TX !== fb[k / BD]) begin errors++; $display("FAIL tx_bit k=%0d: got %b expected %b", k, UART_TX, fb[k / BD]); end
            rd = 1'b0; wr = 1'b0;
            if (second && k == 20) begin wr = 1'b1; addr = BASE | {24'd0, TXD_ADDR}; wdata = {24'd0, b2}; end
            if (k == 40) begin
                rd = 1'b1; addr = BASE | {24'd0, UCON_ADDR};
                #1;
                checks++; if (rdata !== 32'h10) begin errors++; $display("FAIL tx_busy: got %h expected 10", rdata); end
            end
            @(negedge clk);
        end
        rd = 1'b0; wr = 1'b0;
        bus_read(UCON_ADDR, d);
        checks++; if (d !== 32'h04) begin errors++; $display("FAIL tx_done: got %h expected 04", d); end
        bus_read(UCON_ADDR, d);
        checks++; if (d !== 32'h00) begin errors++; $display("FAIL tx_done_clear: got %h expected 00", d); end
        bad = 0;
        repeat (2 * BD) begin
            if (UART_TX !== 1'b1) bad++;
            @(negedge clk);
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL tx_idle: got %0d low cycles expected 0", bad); end
    endtask

    task automatic test_rx(input logic [7:0] b);
        logic [31:0] d;
        send_rx(b, 1'b1);
        last_rx = b;
        bus_read(UCON_ADDR, d);
        checks++; if (d !== 32'h08) begin errors++; $display("FAIL rx_valid: got %h expected 08", d); end
        bus_read(RXD_ADDR, d);
        checks++; if (d !== {24'd0, b}) begin errors++; $display("FAIL rx_data: got %h expected %h", d, {24'd0, b}); end
        bus_read(UCON_ADDR, d);
        checks++; if (d !== 32'h00) begin errors++; $display("FAIL rx_valid_clear: got %h expected 00", d); end
    endtask

    task automatic test_rx_overrun(input logic [7:0] b1, input logic [7:0] b2);
        logic [31:0] d;
        send_rx(b1, 1'b1);
        send_rx(b2, 1'b1);
        last_rx = b2;
        bus_read(UCON_ADDR, d);
        checks++; if (d !== 32'h08) begin errors++; $display("FAIL overrun_valid: got %h expected 08", d); end
        bus_read(RXD_ADDR, d);
        checks++; if (d !== {24'd0, b2}) begin errors++; $display("FAIL overrun_data: got %h expected %h", d, {24'd0, b2}); end
    endtask

    task automatic test_rx_errors(input logic [7:0] b);
        logic [31:0] d;
        UART_RX = 1'b0;
        repeat (4) @(negedge clk);
        UART_RX = 1'b1;
        repeat (3 * BD) @(negedge clk);
        bus_read(UCON_ADDR, d);
        checks++; if (d !== 32'h00) begin errors++; $display("FAIL rx_glitch: got %h expected 00", d); end
        send_rx(b, 1'b0);
        bus_read(UCON_ADDR, d);
        checks++; if (d !== 32'h00) begin errors++; $display("FAIL rx_framing_valid: got %h expected 00", d); end
        bus_read(RXD_ADDR, d);
        checks++; if (d !== {24'd0, last_rx}) begin errors++; $display("FAIL rx_framing_data: got %h expected %h", d, {24'd0, last_rx}); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d;
        bus_write(LED_ADDR, 32'h0000_00FF);
        bus_write(TH_ADDR, $urandom | 32'h1);
        bus_write(TXD_ADDR, 32'h0000_0000);
        repeat (BD + 4) @(negedge clk);
        checks++; if (UART_TX !== 1'b0) begin errors++; $display("FAIL mid_frame_low: got %b expected 0", UART_TX); end
        #2 reset = 1'b1;
        #1;
        checks++; if (UART_TX !== 1'b1) begin errors++; $display("FAIL reset_async_tx: got %b expected 1", UART_TX); end
        checks++; if (led !== 8'h00) begin errors++; $display("FAIL reset_async_led: got %h expected 00", led); end
        @(negedge clk);
        bus_read(TH_ADDR, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_th: got %h expected 0", d); end
        bus_read(UCON_ADDR, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_ucon: got %h expected 0", d); end
        bus_read(RXD_ADDR, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_rxd: got %h expected 0", d); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (UART_TX !== 1'b1) begin errors++; $display("FAIL reset_tx_idle: got %b expected 1", UART_TX); end
    endtask

    initial begin
        logic [31:0] r0, r1;
        @(negedge clk);
        test_reset();
        test_regs(8'hA5, 32'h0000_0FFF, 8'h3C);
        r0 = $urandom; r1 = $urandom;
        test_regs(r0[7:0], r1, r0[15:8]);
        test_timer(32'hFFFF_FFFC, 32'hFFFF_FFFE, 1'b1, 5);
        r0 = $urandom; r1 = $urandom;
        test_timer(r0, 32'hFFFF_FFFF - {30'd0, r1[1:0]}, r1[2], 8);
        test_tx(8'h55, 1'b0, 8'h00);
        test_tx(8'h0F, 1'b1, 8'hF0);
        r0 = $urandom;
        test_tx(r0[7:0], 1'b1, r0[15:8]);
        test_rx(8'hC3);
        r0 = $urandom;
        test_rx(r0[7:0]);
        test_rx_overrun(r0[15:8], r0[23:16]);
        test_rx_errors(r0[31:24]);
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/periph_bus_slave.md
Name: periph_bus_slave

Overview:
Memory-mapped peripheral slave that consumes the CPU data-side bus when addr[30] is set; the CPU qualifies rd and wr with addr[30] before driving them here.
Contains five functions:
- 32-bit reloadable timer with interrupt
- LED output register
- switch input
- 7-segment digit register
- UART transmitter/receiver, timed from the system clock by an internal baud divider

Drives irqout back to the CPU control unit.

Parameters:
BAUD_DIV, 5208, system clocks per UART bit (50 MHz / 9600); benches override to 16.

Ports:
clk  input  1  system clock; all state on posedge.
reset  input  1  asynchronous, active-high reset.
rd  input  1  read strobe, already qualified by addr[30].
wr  input  1  write strobe, already qualified by addr[30].
addr  input  32  byte address; only addr[7:0] is decoded.
wdata  input  32  write data.
rdata  output  32  read data, combinational.
led  output  8  LED register.
switch  input  8  switch inputs.
digi  output  12  digit register.
UART_RX  input  1  asynchronous serial input.
UART_TX  output  1  serial output, idles high.
irqout  output  1  timer interrupt request.

Behaviour:
Register map (offset, access):
- 0x00 TH (rw): reload value.
- 0x04 TL (rw): counter.
- 0x08 TCON (rw): [0] enable, [1] irq_en, [2] irq_status.
- 0x0C LED (rw): [7:0].
- 0x10 SWITCH (ro): {24'b0, switch}.
- 0x14 DIGI (rw): [11:0].
- 0x18 TXD (wo): [7:0] byte to send.
- 0x1C RXD (ro): [7:0] last received byte.
- 0x20 UCON: [2] tx_done (ro, read-clear), [3] rx_valid (ro), [4] tx_busy (ro).

Reads and writes:
- rdata is combinational, valid in the same cycle as rd.
- When rd=0 or the offset is unmapped, rdata=0; unused bits read 0.
- Writes take effect at posedge clk when wr=1. Writes to read-only or unmapped offsets are ignored.

Reset values:
- TH, TL, TCON, led, digi, RXD, and all flags are 0.
- UART_TX=1; both UART FSMs are IDLE.

Timer:
- When TCON[0]=1, TL increments by 1 each cycle.
- When TL==32'hFFFFFFFF, the next TL is TH (wrap/reload); if TCON[1]=1, TCON[2] is set in the same cycle.
- irqout = TCON[1] & TCON[2]. Software clears TCON[2] by writing TCON.
- If a CPU write to TL or TCON coincides with a reload, the write wins.

UART TX FSM, states IDLE, START, DATA, STOP:
- A write to TXD in IDLE latches wdata[7:0], sets tx_busy, and enters START.
- A write to TXD when not IDLE is ignored.
- Each bit lasts BAUD_DIV cycles. Frame order: start bit 0, eight data bits LSB first, stop bit 1.
- At the end of STOP: return to IDLE, clear tx_busy, set tx_done.
- Total frame length is 10*BAUD_DIV cycles.
- tx_done clears at the edge where rd=1 and offset=0x20. If a completion coincides with such a read, the completion wins and the flag stays set.

UART RX FSM, states IDLE, START, DATA, STOP:
- UART_RX passes through a 2-flop synchronizer.
- In IDLE, a synchronized falling edge enters START.
- After BAUD_DIV/2 cycles, if the line is low, go to DATA; if the line is high, treat it as a false start and return to IDLE.
- DATA samples 8 bits, each BAUD_DIV cycles apart, LSB first.
- STOP samples after BAUD_DIV cycles:
  - line=1: load RXD and set rx_valid.
  - line=0: framing error; discard the byte and leave RXD and rx_valid unchanged.
- rx_valid clears at the edge where rd=1 and offset=0x1C.
- Overrun: a new byte overwrites RXD and rx_valid stays 1. A new byte coinciding with an RXD read leaves rx_valid=1.

Reset asserted mid-frame: TX is forced to IDLE with UART_TX=1 immediately (asynchronous); any partial RX byte is discarded.

Decomposition:
- Shared package: register offset constants (TH_ADDR..UCON_ADDR), TCON bit indices, UART state encodings.
- One natural sub-module, uart_rx_core: synchronizer, RX FSM, bit counter, and baud counter. It outputs rx_byte and a one-cycle rx_strobe.
- TX logic and the timer stay in the top module.

Test Plan (all with BAUD_DIV=16):
1. Timer reload: write TH=32'hFFFFFFFC, TL=32'hFFFFFFFE, TCON=3'b011. TL reaches FFFFFFFF after 1 cycle. On the next cycle TL=FFFFFFFC, TCON=3'b111, irqout=1. Writing TCON=3'b011 drops irqout on the following cycle.
2. Reset values and register access: after reset all registers read 0. Write LED=0xA5 and DIGI=0xFFF; reading LED gives 0x000000A5 and led=8'hA5. DIGI reads 0x00000FFF. With switch=8'h3C, SWITCH reads 0x0000003C.
3. TX frame: write TXD=0x55. UART_TX produces 0,1,0,1,0,1,0,1,0,1, each bit 16 cycles, 160 cycles total. Then tx_busy=0 and UCON reads 0x04; a second UCON read returns 0x00.
4. TX busy ignore: write TXD=0x0F, then TXD=0xF0 while busy. Only the 0x0F frame appears on UART_TX.
5. RX: drive the frame for 0xC3 on UART_RX. After the stop bit, UCON[3]=1 and RXD reads 0xC3; UCON[3]=0 after the read. A 4-cycle low glitch yields no byte.
6. RX framing error and reset mid-frame: a stop bit of 0 leaves rx_valid=0. Asserting reset mid-TX frame drives UART_TX=1 within the same cycle and zeroes all registers.
